rsa_modexp_seq: RTL and testbench

- Sequencer for left-to-right square-and-multiply modular exponentiation in the RSA core.
- Scans the latched exponent MSB-first and issues square / multiply commands to the shared modular multiplier over a start/done handshake.
- Drives accumulator-init strobe for the datapath; holds no operand data itself.
- Sits between the top-level RSA control (start/done) and the modmul unit.

---
 rtl/rsa_pkg.sv | 19 +
 rtl/rsa_bit_scan.sv | 59 +++++
 rtl/rsa_modexp_seq.sv | 115 +++++++++++
 tb/tb_rsa_modexp_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA modexp sequencer.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, NEXT, FIN
  } state_t;

  localparam logic MUL_OP_SQR = 1'b0;
  localparam logic MUL_OP_MUL = 1'b1;

  // Index width for a value range 0..v-1; never narrower than 1 bit.
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rsa_bit_scan.sv
// Exponent shift register and bit index, scanned MSB-first.
// With RSA_SEQ_SKIP_LZ_EN it also tracks whether a 1 bit has been processed.
module rsa_bit_scan
  import rsa_pkg::*;
#(
  parameter int EXP_W = 6,
  localparam int IDX_W = clog2(EXP_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [EXP_W-1:0] exp,
  input  logic             advance,
`ifdef RSA_SEQ_SKIP_LZ_EN
  input  logic             mark,
  output logic             first_one,
  output logic             nxt_first,
  output logic             in_lz,
  output logic             all_zero,
`endif
  output logic             cur_bit,
  output logic             last_bit,
  output logic [IDX_W-1:0] bit_idx
);

  logic [EXP_W-1:0] sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh      <= '0;
      bit_idx <= IDX_W'(EXP_W - 1);
    end else if (load) begin
      sh      <= exp;
      bit_idx <= IDX_W'(EXP_W - 1);
    end else if (advance) begin
      sh      <= {sh[EXP_W-2:0], 1'b0};
      bit_idx <= bit_idx - 1'b1;
    end
  end

  assign cur_bit  = sh[EXP_W-1];
  assign last_bit = (bit_idx == '0);

`ifdef RSA_SEQ_SKIP_LZ_EN
  logic seen;

  // seen marks that the first multiply has been issued; leading zeros end there.
  always_ff @(posedge clk) begin
    if (rst || load) seen <= 1'b0;
    else if (mark)   seen <= 1'b1;
  end

  assign in_lz     = ~seen;
  assign first_one = cur_bit & ~seen;
  assign nxt_first = sh[EXP_W-2] & ~seen;
  assign all_zero  = (sh == '0);
`endif

endmodule

// File: rtl/rsa_modexp_seq.sv
// Left-to-right square-and-multiply sequencer driving the shared modmul.
// Define RSA_SEQ_SKIP_LZ_EN to skip leading-zero exponent bits.
module rsa_modexp_seq
  import rsa_pkg::*;
#(
  parameter int EXP_W = 6,
  parameter int CNT_W = 6,
  localparam int IDX_W = clog2(EXP_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [EXP_W-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic             acc_init,
  output logic             mul_start,
  output logic             mul_op,
  input  logic             mul_done,
  output logic [IDX_W-1:0] bit_idx,
  output logic [CNT_W-1:0] sqr_cnt,
  output logic [CNT_W-1:0] mul_cnt
);

  state_t state, nxt;
  logic   accept, cur_bit, last_bit, done_q;
`ifdef RSA_SEQ_SKIP_LZ_EN
  logic   first_one, nxt_first, in_lz, all_zero;
`endif

  assign busy   = (state != IDLE) && (state != FIN);
  assign accept = start && !busy;
  assign done   = done_q;

  rsa_bit_scan #(.EXP_W(EXP_W)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .exp       (exp),
    .advance   ((state == NEXT) && !last_bit),
`ifdef RSA_SEQ_SKIP_LZ_EN
    .mark      (state == MUL_REQ),
    .first_one (first_one),
    .nxt_first (nxt_first),
    .in_lz     (in_lz),
    .all_zero  (all_zero),
`endif
    .cur_bit   (cur_bit),
    .last_bit  (last_bit),
    .bit_idx   (bit_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    acc_init  = 1'b0;
    mul_start = 1'b0;
    mul_op    = MUL_OP_SQR;
    case (state)
      IDLE, FIN: nxt = accept ? LOAD : IDLE;
      LOAD: begin
        acc_init = 1'b1;
`ifdef RSA_SEQ_SKIP_LZ_EN
        if (all_zero)       nxt = FIN;
        else if (first_one) nxt = MUL_REQ;
        else                nxt = NEXT;
`else
        nxt = SQR_REQ;
`endif
      end
      SQR_REQ: begin
        mul_start = 1'b1;
        nxt       = SQR_WAIT;
      end
      SQR_WAIT: if (mul_done) nxt = cur_bit ? MUL_REQ : NEXT;
      MUL_REQ: begin
        mul_start = 1'b1;
        mul_op    = MUL_OP_MUL;
        nxt       = MUL_WAIT;
      end
      MUL_WAIT: if (mul_done) nxt = NEXT;
      NEXT: begin
        if (last_bit) nxt = FIN;
`ifdef RSA_SEQ_SKIP_LZ_EN
        // Still in the leading zeros: the first 1 gets a bare multiply.
        else if (nxt_first) nxt = MUL_REQ;
        else if (in_lz)     nxt = NEXT;
`endif
        else nxt = SQR_REQ;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= 1'b0;
      sqr_cnt <= '0;
      mul_cnt <= '0;
    end else if (accept) begin
      done_q  <= 1'b0;
      sqr_cnt <= '0;
      mul_cnt <= '0;
    end else begin
      if (nxt == FIN) done_q <= 1'b1;
      if (state == SQR_REQ && sqr_cnt != '1) sqr_cnt <= sqr_cnt + 1'b1;
      if (state == MUL_REQ && mul_cnt != '1) mul_cnt <= mul_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Directed bench for rsa_modexp_seq; expectations follow RSA_SEQ_SKIP_LZ_EN.
module tb_rsa_modexp_seq;

  logic       clk = 1'b0;
  logic       rst, start, mul_done;
  logic [5:0] exp;
  logic       busy, done, acc_init, mul_start, mul_op;
  logic [2:0] bit_idx;
  logic [5:0] sqr_cnt, mul_cnt;

  int nchk = 0;
  int nerr = 0;

  rsa_modexp_seq #(.EXP_W(6), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .exp(exp),
    .busy(busy), .done(done), .acc_init(acc_init),
    .mul_start(mul_start), .mul_op(mul_op), .mul_done(mul_done),
    .bit_idx(bit_idx), .sqr_cnt(sqr_cnt), .mul_cnt(mul_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  e;
    int          lat;
    int          n;
    logic [15:0] ops;   // bit i = 1 when op i is a multiply
    int          sq;
    int          mu;
  } vec_t;

  vec_t vec[5];

  task automatic chk(input string name, input int act, input int want);
    nchk++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".done"}, int'(done), 0);
    chk({tag, ".acc_init"}, int'(acc_init), 0);
    chk({tag, ".mul_start"}, int'(mul_start), 0);
    chk({tag, ".mul_op"}, int'(mul_op), 0);
    chk({tag, ".bit_idx"}, int'(bit_idx), 5);
    chk({tag, ".sqr_cnt"}, int'(sqr_cnt), 0);
    chk({tag, ".mul_cnt"}, int'(mul_cnt), 0);
  endtask

  // Starts a run, answers each mul_start after lat cycles, checks the outcome.
  task automatic run(input string tag, input vec_t v, input bit inject);
    logic [15:0] opv = '0;
    int n = 0, cd = -1, cyc = 0, md_cyc = -100, acc_n = 0;
    bit stray_done = 0;
    @(negedge clk);
    start = 1'b1; exp = v.e;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_on"}, int'(busy), 1);
    chk({tag, ".done_clr"}, int'(done), 0);
    while (!done && cyc < 600) begin
      mul_done = 1'b0;
      start    = 1'b0;
      if (cd == 0) begin
        mul_done = 1'b1; cd = -1; md_cyc = cyc;
      end else if (cd > 0) cd--;
      if (acc_init) acc_n++;
      if (mul_start) begin
        if (n < 16) opv[n] = mul_op;
        n++;
        cd = v.lat - 1;
        if (inject && !stray_done && !mul_op) begin
          mul_done = 1'b1; stray_done = 1;
        end
        if (inject && n == 2) begin
          start = 1'b1; exp = 6'b111111;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mul_done = 1'b0; start = 1'b0;
    chk({tag, ".finished"}, int'(done), 1);
    chk({tag, ".n_ops"}, n, v.n);
    chk({tag, ".ops"}, int'(opv), int'(v.ops));
    chk({tag, ".sqr_cnt"}, int'(sqr_cnt), v.sq);
    chk({tag, ".mul_cnt"}, int'(mul_cnt), v.mu);
    chk({tag, ".busy_off"}, int'(busy), 0);
    chk({tag, ".acc_init_n"}, acc_n, 1);
    if (n > 0) chk({tag, ".done_gap"}, cyc - md_cyc, 2);
    @(negedge clk);
    chk({tag, ".done_hold"}, int'(done), 1);
    exp = 6'b0;
  endtask

  initial begin
`ifdef RSA_SEQ_SKIP_LZ_EN
    vec[0] = '{6'b000101, 3, 4,  16'h0009, 2, 2};
    vec[1] = '{6'b000000, 3, 0,  16'h0000, 0, 0};
    vec[2] = '{6'b111111, 2, 11, 16'h0555, 5, 6};
    vec[3] = '{6'b100000, 1, 6,  16'h0001, 5, 1};
    vec[4] = '{6'b101101, 2, 9,  16'h0129, 5, 4};
`else
    vec[0] = '{6'b000101, 3, 8,  16'h0090, 6, 2};
    vec[1] = '{6'b000000, 3, 6,  16'h0000, 6, 0};
    vec[2] = '{6'b111111, 2, 12, 16'h0AAA, 6, 6};
    vec[3] = '{6'b100000, 1, 7,  16'h0002, 6, 1};
    vec[4] = '{6'b101101, 2, 10, 16'h0252, 6, 4};
`endif
    rst = 1'b1; start = 1'b0; mul_done = 1'b0; exp = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset("reset");

    for (int i = 0; i < 5; i++) run($sformatf("vec%0d", i), vec[i], 1'b0);

    // Mid-run start and a stray mul_done in SQR_REQ must be ignored.
    run("ignore", vec[0], 1'b1);

    // Reset while waiting on a multiply, then a late mul_done.
    begin
      int guard = 0;
      @(negedge clk);
      start = 1'b1; exp = 6'b111111;
      @(negedge clk);
      start = 1'b0;
      while (!(mul_start && mul_op) && guard < 100) begin
        if (mul_start) begin
          mul_done = 1'b0;
          @(negedge clk);
          mul_done = 1'b1;
        end
        @(negedge clk);
        mul_done = 1'b0;
        guard++;
      end
      chk("rst.reach_mul", int'(mul_start && mul_op), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset("rst_mid");
      mul_done = 1'b1;
      @(negedge clk);
      mul_done = 1'b0;
      chk_reset("late_done");
      @(negedge clk);
      chk("late.mul_start", int'(mul_start), 0);
      chk("late.busy", int'(busy), 0);
    end
    run("after_rst", vec[2], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
